i2s_frame_tx: RTL

//  Transmit end of the LED panel serial stream: builds one 16-bit header + pixel payload per display row, MSB first, on i2s_data.

---
 rtl/i2s_led_pkg.sv | 22 ++
 rtl/i2s_tx_nibble_addr.sv | 41 ++++
 rtl/i2s_frame_tx.sv | 135 +++++++++++++
 3 files changed

// File: rtl/i2s_led_pkg.sv
// i2s_led_pkg: shared header layout, pixel geometry and FSM state type for the LED panel stream
package i2s_led_pkg;
  localparam int HDR_BITS = 16;
  localparam int MOD_PIX  = 4;
  localparam int NX_MSB   = 15;
  localparam int NY_MSB   = 11;
  localparam int ROW_MSB  = 5;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } tx_state_e;
  function automatic logic [HDR_BITS-1:0] hdr_word(input logic [3:0] nx, input logic [3:0] ny,
                                                   input logic [5:0] row);
    logic [HDR_BITS-1:0] w;
    w = '0;
    w[NX_MSB -: 4]  = nx;
    w[NY_MSB -: 4]  = ny;
    w[ROW_MSB -: 6] = row;
    return w;
  endfunction
endpackage

// File: rtl/i2s_tx_nibble_addr.sv
// i2s_tx_nibble_addr: mx/sub/my nested counters tracking the next payload nibble to fetch
module i2s_tx_nibble_addr
  import i2s_led_pkg::*;
#(
  parameter int NIB_ADDR_W = 10
) (
  input  logic                  i2s_clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  adv,
  input  logic [3:0]            nx,
  input  logic [3:0]            ny,
  output logic [3:0]            mx,
  output logic [1:0]            sub,
  output logic [3:0]            my,
  output logic [NIB_ADDR_W-1:0] nib_idx,
  output logic                  last
);
  logic mx_end, sub_end;
  assign mx_end  = mx == nx;
  assign sub_end = sub == 2'(MOD_PIX - 1);
  assign last    = mx_end && sub_end && my == ny;
  // transmit order is mx fastest, then sub, then my, so the index ((my*4+sub)*(nx+1)+mx) is a plain up-counter
  always_ff @(posedge i2s_clk or negedge rst_n)
    if (!rst_n) begin
      mx      <= '0;
      sub     <= '0;
      my      <= '0;
      nib_idx <= '0;
    end else if (clr) begin
      mx      <= '0;
      sub     <= '0;
      my      <= '0;
      nib_idx <= '0;
    end else if (adv && !last) begin
      mx      <= mx_end ? 4'd0 : mx + 4'd1;
      sub     <= mx_end ? (sub_end ? 2'd0 : sub + 2'd1) : sub;
      my      <= (mx_end && sub_end) ? my + 4'd1 : my;
      nib_idx <= nib_idx + 1'b1;
    end
endmodule

// File: rtl/i2s_frame_tx.sv
// i2s_frame_tx: per-row header + pixel payload serializer for the LED panel stream (test pattern option: TX_TESTPAT_EN)
module i2s_frame_tx
  import i2s_led_pkg::*;
#(
  parameter int ROW_W      = 6,
  parameter int NIB_ADDR_W = 10
) (
  input  logic                        i2s_clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [3:0]                  cfg_nx,
  input  logic [3:0]                  cfg_ny,
  input  logic [ROW_W-1:0]            cfg_rows,
  input  logic                        test_mode,
  output logic                        rd_en,
  output logic [ROW_W+NIB_ADDR_W-1:0] rd_addr,
  input  logic [3:0]                  rd_data,
  output logic                        i2s_data,
  output logic                        tx_active,
  output logic                        frame_done
);
  tx_state_e st, st_nxt;
  logic [3:0] hdr_cnt, nx_l, ny_l, shift_q, ld_nib, mx, my;
  logic [11:0] pay_cnt, p_last;
  logic [ROW_W-1:0] rows_l, row;
  logic [1:0] sub;
  logic [NIB_ADDR_W-1:0] nib_idx;
  logic [HDR_BITS-1:0] hdr;
  logic hdr_end, pay_end, start_hdr, nib_clr, nib_last, fetch, cap, fetched_all, tx_bit, tp_row;

  assign hdr_end   = st == ST_HDR && hdr_cnt == 4'(HDR_BITS - 1);
  assign pay_end   = st == ST_PAY && pay_cnt == p_last;
  assign start_hdr = st_nxt == ST_HDR && st != ST_HDR;
  assign nib_clr   = st == ST_IDLE || (st == ST_HDR && hdr_cnt == 4'd0);
  assign hdr       = hdr_word(nx_l, ny_l, 6'(row));

  i2s_tx_nibble_addr #(.NIB_ADDR_W(NIB_ADDR_W)) u_addr (
    .i2s_clk (i2s_clk),
    .rst_n   (rst_n),
    .clr     (nib_clr),
    .adv     (fetch),
    .nx      (nx_l),
    .ny      (ny_l),
    .mx      (mx),
    .sub     (sub),
    .my      (my),
    .nib_idx (nib_idx),
    .last    (nib_last)
  );

  // state register
  always_ff @(posedge i2s_clk or negedge rst_n)
    if (!rst_n) st <= ST_IDLE;
    else st <= st_nxt;

  // next state: enable is only looked at when a row could start
  always_comb begin
    st_nxt = ST_IDLE;
    if (st == ST_IDLE) st_nxt = enable ? ST_HDR : ST_IDLE;
    else if (st == ST_HDR) st_nxt = hdr_end ? ST_PAY : ST_HDR;
    else if (st == ST_PAY) st_nxt = pay_end ? (enable ? ST_HDR : ST_IDLE) : ST_PAY;
  end

  // outputs: fetch two bits ahead of each nibble so the data lands exactly at the nibble boundary
  always_comb begin
    fetch   = (st == ST_HDR && hdr_cnt == 4'(HDR_BITS - 2)) ||
              (st == ST_PAY && pay_cnt[1:0] == 2'd2 && !fetched_all);
    rd_en   = fetch && !tp_row;
    rd_addr = {row, nib_idx};
    tx_bit  = st == ST_HDR ? hdr[~hdr_cnt] : st == ST_PAY ? shift_q[3] : 1'b0;
  end

  // per-row configuration, frozen at header start so mid-row changes wait for the next row
  always_ff @(posedge i2s_clk or negedge rst_n)
    if (!rst_n) begin
      nx_l   <= '0;
      ny_l   <= '0;
      rows_l <= '0;
      p_last <= '0;
    end else if (start_hdr) begin
      nx_l   <= cfg_nx;
      ny_l   <= cfg_ny;
      rows_l <= cfg_rows;
      p_last <= {8'(({1'b0, cfg_nx} + 5'd1) * ({1'b0, cfg_ny} + 5'd1) - 10'd1), 4'hF};
    end

  // bit counters, row counter, frame pulse and payload shifter
  always_ff @(posedge i2s_clk or negedge rst_n)
    if (!rst_n) begin
      hdr_cnt     <= '0;
      pay_cnt     <= '0;
      row         <= '0;
      frame_done  <= 1'b0;
      cap         <= 1'b0;
      fetched_all <= 1'b0;
      shift_q     <= '0;
    end else begin
      hdr_cnt     <= st == ST_HDR ? hdr_cnt + 4'd1 : 4'd0;
      pay_cnt     <= (st == ST_PAY && !pay_end) ? pay_cnt + 12'd1 : 12'd0;
      frame_done  <= pay_end && row >= rows_l;
      if (pay_end) row <= (row >= rows_l) ? '0 : row + 1'b1;
      cap         <= fetch;
      fetched_all <= nib_clr ? 1'b0 : fetched_all | (fetch & nib_last);
      shift_q     <= cap ? ld_nib : {shift_q[2:0], 1'b0};
    end

`ifdef TX_TESTPAT_EN
  logic [3:0] tp_nib;
  // test pattern: mode frozen per row, nibble generated at fetch time and staged like a buffer read
  always_ff @(posedge i2s_clk or negedge rst_n)
    if (!rst_n) begin
      tp_row <= 1'b0;
      tp_nib <= '0;
    end else begin
      if (start_hdr) tp_row <= test_mode;
      if (fetch) tp_nib <= mx ^ my ^ {2'b00, sub} ^ {2'b00, row[1:0]};
    end
  assign ld_nib = tp_row ? tp_nib : rd_data;
`else
  logic unused_tp;
  assign tp_row    = 1'b0;
  assign ld_nib    = rd_data;
  assign unused_tp = ^{test_mode, mx, my, sub};
`endif

  // launch on the falling edge so receivers sample mid-bit on the next rising edge
  always_ff @(negedge i2s_clk or negedge rst_n)
    if (!rst_n) begin
      i2s_data  <= 1'b0;
      tx_active <= 1'b0;
    end else begin
      i2s_data  <= tx_bit;
      tx_active <= st != ST_IDLE;
    end
endmodule
